// File: rtl/mem_lsu_pkg.sv
// Shared load/store encodings and request legality helpers for mem_lsu.
// MISALIGN_SPLIT_EN selects word-straddling split support; undefined rejects misaligned accesses.
package mem_lsu_pkg;

  typedef logic [2:0] dm_type_t;

  localparam dm_type_t DM_WORD              = 3'b000;
  localparam dm_type_t DM_HALFWORD          = 3'b001;
  localparam dm_type_t DM_HALFWORD_UNSIGNED = 3'b010;
  localparam dm_type_t DM_BYTE              = 3'b011;
  localparam dm_type_t DM_BYTE_UNSIGNED     = 3'b100;

`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  function automatic logic [2:0] dm_size(dm_type_t t);
    case (t)
      DM_WORD:                           return 3'd4;
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: return 3'd2;
      default:                           return 3'd1;
    endcase
  endfunction

  // Requests flagged here complete immediately with an error and never touch memory.
  function automatic logic dm_req_err(dm_type_t t, logic [1:0] off);
    logic misaligned;
    misaligned = ((dm_size(t) == 3'd4) && (off != 2'b00)) ||
                 ((dm_size(t) == 3'd2) && off[0]);
    return (t > DM_BYTE_UNSIGNED) || (!SPLIT_EN && misaligned);
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Pipeline-side request/response bundle and word-memory port bundle for mem_lsu.
interface mem_lsu_req_if;
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  mem_lsu_pkg::dm_type_t     req_type;
  logic [31:0]               req_addr;
  logic [31:0]               req_wdata;
  logic                      resp_valid;
  logic [31:0]               resp_rdata;
  logic                      resp_err;

  modport master (output req_valid, req_we, req_type, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_we, req_type, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

interface mem_lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane placement (byte enables, write data) and load extraction/extension.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  dm_type_t    type_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic        split_o,
  output logic [31:0] rdata_o
);

  logic [2:0]  size;
  logic [3:0]  mask;
  logic [31:0] x;

  always_comb begin
    size    = dm_size(type_i);
    mask    = 4'b1111 >> (3'd4 - size);
    be_o    = {4'b0000, mask} << off_i;
    wdata_o = {32'b0, wdata_i} << {off_i, 3'b000};
    split_o = ({1'b0, size} + {2'b00, off_i}) > 4'd4;

    x = 32'({hi_i, lo_i} >> {off_i, 3'b000});
    case (type_i)
      DM_HALFWORD:          rdata_o = {{16{x[15]}}, x[15:0]};
      DM_HALFWORD_UNSIGNED: rdata_o = {16'b0, x[15:0]};
      DM_BYTE:              rdata_o = {{24{x[7]}}, x[7:0]};
      DM_BYTE_UNSIGNED:     rdata_o = {24'b0, x[7:0]};
      default:              rdata_o = x;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one access per handshake, split into aligned word transactions held until mem_ack.
// Feature macro MISALIGN_SPLIT_EN (see mem_lsu_pkg) enables two-word accesses for straddling requests.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mem_lsu_req_if.slave    req,
  mem_lsu_mem_if.master   mem
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  dm_type_t    type_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] lo_q, lo_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        accept, finish, split;
  logic [7:0]  be8;
  logic [63:0] wdata64;
  logic [31:0] lo_in, hi_in, load_data, base_addr;

  lsu_align u_align (
    .type_i  (type_q),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .hi_i    (hi_in),
    .lo_i    (lo_in),
    .be_o    (be8),
    .wdata_o (wdata64),
    .split_o (split),
    .rdata_o (load_data)
  );

  always_comb begin
    state_d        = state_q;
    lo_d           = lo_q;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;
    accept         = 1'b0;
    finish         = 1'b0;
    lo_in          = lo_q;
    hi_in          = 32'b0;
    base_addr      = {addr_q[31:2], 2'b00};
    req.req_ready  = 1'b0;
    req.resp_valid = 1'b0;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = 32'b0;
    mem.mem_be     = 4'b0;
    mem.mem_wdata  = 32'b0;

    case (state_q)
      IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid) begin
          accept = 1'b1;
          if (dm_req_err(req.req_type, req.req_addr[1:0])) begin
            state_d      = RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'b0;
          end else begin
            state_d = ACC0;
          end
        end
      end
      ACC0: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = base_addr;
        mem.mem_be    = be8[3:0];
        mem.mem_wdata = wdata64[31:0];
        // Feed the live read word so a single-word load resolves in the ack cycle.
        lo_in         = mem.mem_rdata;
        if (mem.mem_ack) begin
          lo_d = mem.mem_rdata;
          if (SPLIT_EN && split) begin
            state_d = ACC1;
          end else begin
            state_d = RESP;
            finish  = 1'b1;
          end
        end
      end
      ACC1: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = base_addr + 32'd4;
        mem.mem_be    = be8[7:4];
        mem.mem_wdata = wdata64[63:32];
        hi_in         = mem.mem_rdata;
        if (mem.mem_ack) begin
          state_d = RESP;
          finish  = 1'b1;
        end
      end
      RESP: begin
        req.resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      resp_err_d   = 1'b0;
      resp_rdata_d = we_q ? 32'b0 : load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      type_q       <= DM_WORD;
      addr_q       <= 32'b0;
      wdata_q      <= 32'b0;
      lo_q         <= 32'b0;
      resp_rdata_q <= 32'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      if (accept) begin
        we_q    <= req.req_we;
        type_q  <= req.req_type;
        addr_q  <= req.req_addr;
        wdata_q <= req.req_wdata;
      end
    end
  end

  assign req.resp_rdata = resp_rdata_q;
  assign req.resp_err   = resp_err_q;

endmodule
